// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser, stability filter, edge strobes and auto-repeat
module debounce_multi #(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 1000000,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   REPEAT_DELAY  = 25000000,
  parameter int   REPEAT_PERIOD = 5000000
) (
  input  logic                clock_in,
  input  logic                reset_n_in,
  input  logic [CHANNELS-1:0] noisy_in,
  input  logic [CHANNELS-1:0] repeat_en_in,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] rise_out,
  output logic [CHANNELS-1:0] fall_out,
  output logic [CHANNELS-1:0] repeat_out
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  // DELAY is entered one cycle after the enabling cycle, so its terminal count is one less
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 2);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DELAY, PERIOD} state_t;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          r_sync1, r_sync2, r_cand, r_clean, r_rise, r_fall, r_rep;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_rpt;
    state_t        r_state;
    logic          w_accept;
    assign w_accept = (r_sync2 == r_cand) && (r_cnt == CNT_MAX);
    always_ff @(posedge clock_in or negedge reset_n_in)
      if (!reset_n_in) begin
        r_sync1 <= RESET_LEVEL;
        r_sync2 <= RESET_LEVEL;
        r_cand  <= RESET_LEVEL;
        r_clean <= RESET_LEVEL;
        r_cnt   <= '0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_rep   <= 1'b0;
        r_rpt   <= '0;
        r_state <= IDLE;
      end else begin
        r_sync1 <= noisy_in[g];
        r_sync2 <= r_sync1;
        r_cand  <= r_sync2;
        r_cnt   <= (r_sync2 != r_cand) ? '0 : (r_cnt == CNT_MAX ? r_cnt : r_cnt + 1'b1);
        if (w_accept) r_clean <= r_cand;
        r_rise  <= w_accept && r_cand && !r_clean;
        r_fall  <= w_accept && !r_cand && r_clean;
        r_rep   <= 1'b0;
        r_rpt   <= '0;
        if (!r_clean || !repeat_en_in[g]) r_state <= IDLE;
        else
          case (r_state)
            IDLE: r_state <= DELAY;
            DELAY:
              if (r_rpt == DLY_LAST) begin
                r_state <= PERIOD;
                r_rep   <= 1'b1;
              end else r_rpt <= r_rpt + 1'b1;
            default:
              if (r_rpt == PER_LAST) r_rep <= 1'b1;
              else r_rpt <= r_rpt + 1'b1;
          endcase
      end
    assign clean_out[g]  = r_clean;
    assign rise_out[g]   = r_rise;
    assign fall_out[g]   = r_fall;
    assign repeat_out[g] = r_rep;
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed and random stimulus against a sample-history reference model
module tb_debounce_multi;
  localparam int   CH = 4;
  localparam int   S  = 8;
  localparam int   D  = 20;
  localparam int   P  = 5;
  localparam logic RL = 1'b0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0] noisy = '0, en = '0;
  logic [CH-1:0] pins = '0, ens = '0;
  logic [CH-1:0] clean, rise, fall, rep;
  int n_chk = 0, n_fail = 0;
  logic [1:0] hist [CH][S+3];
  logic [CH-1:0] m_clean, m_rise, m_fall, m_rep;
  int run_len [CH];
  debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(S), .RESET_LEVEL(RL),
                   .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clock_in(clk), .reset_n_in(rst_n), .noisy_in(noisy), .repeat_en_in(en),
    .clean_out(clean), .rise_out(rise), .fall_out(fall), .repeat_out(rep));
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // reset leaves three valid samples at RESET_LEVEL; older history counts as broken
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < S + 3; k++) hist[c][k] = (k < 3) ? {1'b0, RL} : 2'd2;
      run_len[c] = 0;
    end
    m_clean = {CH{RL}};
    m_rise = '0;
    m_fall = '0;
    m_rep = '0;
  endtask
  // clean follows a pin once S+1 consecutive samples, seen two edges late, agree
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      logic nc;
      bit stable;
      run_len[c] = (m_clean[c] && en[c]) ? run_len[c] + 1 : 0;
      m_rep[c] = run_len[c] >= D && (run_len[c] - D) % P == 0;
      for (int k = S + 2; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = {1'b0, noisy[c]};
      stable = 1'b1;
      for (int k = 3; k < S + 3; k++) if (hist[c][k] != hist[c][2]) stable = 1'b0;
      nc = stable ? hist[c][2][0] : m_clean[c];
      m_rise[c] = nc && !m_clean[c];
      m_fall[c] = !nc && m_clean[c];
      m_clean[c] = nc;
    end
  endtask
  task automatic compare_all(string tag);
    check({tag, "_clean"}, int'(clean), int'(m_clean));
    check({tag, "_rise"}, int'(rise), int'(m_rise));
    check({tag, "_fall"}, int'(fall), int'(m_fall));
    check({tag, "_repeat"}, int'(rep), int'(m_rep));
  endtask
  task automatic tick();
    @(negedge clk);
    noisy = pins;
    en = ens;
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    compare_all("cyc");
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
  endtask
  task automatic wait_bit(string tag, input int ch, input bit want_rise);
    int k = 0;
    while (k < 40 && !(want_rise ? rise[ch] : fall[ch])) begin
      tick();
      k++;
    end
    check(tag, k < 40, 1);
  endtask
  initial begin
    int hold [CH];
    int cnt;
    model_reset();
    #1 compare_all("por");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    pins[0] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("press_rise0", int'(rise[0]), int'(i == 11));
    end
    cnt = 0;
    foreach (hold[j]) hold[j] = 0;
    for (int i = 0; i < 21; i++) begin
      pins[1] = (i < 3) || (i >= 5 && i < 10) || (i >= 12 && i < 19);
      tick();
      cnt += int'(rise[1]);
    end
    pins[1] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      cnt += int'(rise[1]);
      if (i == 11) check("bounce_rise1", int'(rise[1]), 1);
    end
    check("bounce_count", cnt, 1);
    ens[2] = 1'b1;
    pins[2] = 1'b1;
    wait_bit("rpt_wait_rise", 2, 1'b1);
    cnt = 0;
    for (int k = 1; k <= 47; k++) begin
      tick();
      check("rpt_pulse", int'(rep[2]), int'(k >= 20 && (k - 20) % 5 == 0));
      cnt += int'(rep[2]);
    end
    pins[2] = 1'b0;
    for (int k = 48; k <= 62 && !fall[2]; k++) begin
      tick();
      cnt += int'(rep[2]);
    end
    check("rpt_fall", int'(fall[2]), 1);
    check("rpt_count", cnt, 8);
    cnt = 0;
    repeat (20) begin
      tick();
      cnt += int'(rep[2]);
    end
    check("rpt_after_fall", cnt, 0);
    pins[2] = 1'b1;
    wait_bit("dis_wait_rise", 2, 1'b1);
    repeat (22) tick();
    ens[2] = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick();
      cnt += int'(rep[2]);
    end
    check("dis_no_repeat", cnt, 0);
    pins[3] = 1'b1;
    repeat (8) tick();
    do_reset();
    check("rst_clean", int'(clean), 0);
    for (int i = 1; i <= 13; i++) begin
      tick();
      check("rst_rise3", int'(rise[3]), int'(i == 11));
    end
    pins = '0;
    ens = '0;
    repeat (15) tick();
    pins = '1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("par_rise", int'(rise), (i == 11) ? 'hf : 0);
    end
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          pins[c] = ~pins[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 45);
        end else hold[c]--;
        if ($urandom_range(0, 59) == 0) ens[c] = ~ens[c];
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
